id_branch_ctrl: RTL and testbench

ID_BRANCH_CTRL -- requirements
Module: id_branch_ctrl

---
 rtl/sparc_pkg.sv | 33 +++
 rtl/cti_decode.sv | 52 +++++
 rtl/id_branch_ctrl.sv | 104 ++++++++++
 tb/tb_id_branch_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_pkg.sv
// Shared SPARC control-transfer encodings, IF mux selects and the ID branch FSM state type.
package sparc_pkg;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_ARITH  = 2'b10;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [5:0] OP3_JMPL  = 6'b111000;

    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BN   = 4'b0000;

    localparam logic [1:0] SEL_NPC   = 2'b00;
    localparam logic [1:0] SEL_ALU   = 2'b01;
    localparam logic [1:0] SEL_TA    = 2'b10;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        DSLOT  = 2'b01,
        ANNUL  = 2'b10
    } id_state_t;

    typedef struct packed {
        logic is_call;
        logic is_bicc;
        logic is_jmpl;
        logic annul;
        logic is_ba;
        logic taken;
    } cti_info_t;

endpackage

// File: rtl/cti_decode.sv
// Combinational CTI decode of the ID instruction plus branch/call target arithmetic.
module cti_decode
    import sparc_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        cond_true,
    output cti_info_t   info,
    output logic [31:0] ta
);

    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic [3:0]  cond;
    logic [31:0] bicc_off;
    logic [31:0] call_off;

    assign op       = instr[31:30];
    assign op2      = instr[24:22];
    assign op3      = instr[24:19];
    assign cond     = instr[28:25];
    assign bicc_off = {{8{instr[21]}}, instr[21:0], 2'b00};
    assign call_off = {instr[29:0], 2'b00};

    always_comb begin
        info         = '0;
        info.is_call = (op == OP_CALL);
        info.is_bicc = (op == OP_BRANCH) && (op2 == OP2_BICC);
        info.is_jmpl = (op == OP_ARITH) && (op3 == OP3_JMPL);
        info.annul   = instr[29];
        info.is_ba   = info.is_bicc && (cond == COND_BA);
        // BA and BN ignore the condition codes entirely.
        if (info.is_bicc) begin
            if (cond == COND_BA)
                info.taken = 1'b1;
            else if (cond == COND_BN)
                info.taken = 1'b0;
            else
                info.taken = cond_true;
        end
    end

    always_comb begin
        ta = '0;
        if (info.is_bicc)
            ta = pc + bicc_off;
        else if (info.is_call)
            ta = pc + call_off;
    end

endmodule

// File: rtl/id_branch_ctrl.sv
// ID-stage branch controller: IF redirect/annul generation, delay-slot FSM and CTI counters.
module id_branch_ctrl
    import sparc_pkg::*;
(
    input  logic        clk,
    input  logic        R,
    input  logic [31:0] instr_id,
    input  logic [31:0] pc_id,
    input  logic        cond_true,
    input  logic        stall,
    output logic [1:0]  if_sel,
    output logic [31:0] ta,
    output logic        ch_clear,
    output logic        pc_le,
    output logic        npc_le,
    output logic        ifid_le,
    output logic        id_valid,
    output logic        in_dslot,
    output logic [15:0] cnt_taken,
    output logic [15:0] cnt_annul
);

    cti_info_t info;
    id_state_t state_q;
    logic      id_valid_q;
    logic      in_dslot_q;
    logic      live;
    logic      is_cti;

    cti_decode u_decode (
        .instr     (instr_id),
        .pc        (pc_id),
        .cond_true (cond_true),
        .info      (info),
        .ta        (ta)
    );

    assign is_cti   = info.is_call | info.is_bicc | info.is_jmpl;
    // A CTI in a delay slot (DCTI couple) is not live, so it redirects nothing.
    assign live     = id_valid_q && (state_q == NORMAL) && !stall;
    assign pc_le    = ~stall;
    assign npc_le   = ~stall;
    assign ifid_le  = ~stall;
    assign id_valid = id_valid_q;
    assign in_dslot = in_dslot_q;

    always_comb begin
        if_sel   = SEL_NPC;
        ch_clear = 1'b0;
        if (live) begin
            if (info.taken || info.is_call)
                if_sel = SEL_TA;
            else if (info.is_jmpl)
                if_sel = SEL_ALU;
            if (info.is_bicc && info.annul && (!info.taken || info.is_ba))
                ch_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q    <= NORMAL;
            id_valid_q <= 1'b1;
            in_dslot_q <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                NORMAL: begin
                    if (ch_clear) begin
                        state_q    <= ANNUL;
                        id_valid_q <= 1'b0;
                        in_dslot_q <= 1'b0;
                    end else if (live && is_cti) begin
                        state_q    <= DSLOT;
                        id_valid_q <= 1'b1;
                        in_dslot_q <= 1'b1;
                    end
                end
                DSLOT, ANNUL: begin
                    state_q    <= NORMAL;
                    id_valid_q <= 1'b1;
                    in_dslot_q <= 1'b0;
                end
                default: begin
                    state_q    <= NORMAL;
                    id_valid_q <= 1'b1;
                    in_dslot_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            cnt_taken <= '0;
            cnt_annul <= '0;
        end else begin
            if ((if_sel != SEL_NPC) && !stall && (cnt_taken != 16'hFFFF))
                cnt_taken <= cnt_taken + 16'd1;
            if (ch_clear && !stall && (cnt_annul != 16'hFFFF))
                cnt_annul <= cnt_annul + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Scoreboard bench for id_branch_ctrl: directed CTI scenarios then a randomized instruction mix.
module tb_id_branch_ctrl;

    typedef struct {
        logic [1:0]  if_sel;
        logic [31:0] ta;
        logic        ch_clear;
        logic        en;
        logic        id_valid;
        logic        in_dslot;
        logic [15:0] ct;
        logic [15:0] ca;
        int          seq;
    } exp_t;

    logic        clk;
    logic        R;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic        cond_true;
    logic        stall;
    logic [1:0]  if_sel;
    logic [31:0] ta;
    logic        ch_clear;
    logic        pc_le;
    logic        npc_le;
    logic        ifid_le;
    logic        id_valid;
    logic        in_dslot;
    logic [15:0] cnt_taken;
    logic [15:0] cnt_annul;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   issued = 0;

    bit   m_slot  = 0;
    bit   m_annul = 0;
    int   m_taken = 0;
    int   m_acnt  = 0;

    id_branch_ctrl dut (
        .clk       (clk),
        .R         (R),
        .instr_id  (instr_id),
        .pc_id     (pc_id),
        .cond_true (cond_true),
        .stall     (stall),
        .if_sel    (if_sel),
        .ta        (ta),
        .ch_clear  (ch_clear),
        .pc_le     (pc_le),
        .npc_le    (npc_le),
        .ifid_le   (ifid_le),
        .id_valid  (id_valid),
        .in_dslot  (in_dslot),
        .cnt_taken (cnt_taken),
        .cnt_annul (cnt_annul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int seq, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want)
            passes++;
        else
            $display("[TB] FAIL %s seq=%0d actual=%h required=%h", name, seq, act, want);
    endtask

    task automatic checkOutput(input exp_t e);
        chk("if_sel",    e.seq, 32'(if_sel),    32'(e.if_sel));
        chk("ta",        e.seq, ta,             e.ta);
        chk("ch_clear",  e.seq, 32'(ch_clear),  32'(e.ch_clear));
        chk("pc_le",     e.seq, 32'(pc_le),     32'(e.en));
        chk("npc_le",    e.seq, 32'(npc_le),    32'(e.en));
        chk("ifid_le",   e.seq, 32'(ifid_le),   32'(e.en));
        chk("id_valid",  e.seq, 32'(id_valid),  32'(e.id_valid));
        chk("in_dslot",  e.seq, 32'(in_dslot),  32'(e.in_dslot));
        chk("cnt_taken", e.seq, 32'(cnt_taken), 32'(e.ct));
        chk("cnt_annul", e.seq, 32'(cnt_annul), 32'(e.ca));
    endtask

    // Reference model: the pipeline is either free, carrying a delay slot, or carrying an annulled slot.
    task automatic applyStimulus(input logic rst_v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic ct, input logic st);
        exp_t   e;
        int     op, op2, op3, cond;
        bit     a, bicc, call, jmpl, taken, live;
        longint off, tgt;
        @(posedge clk);
        #1;
        R         = rst_v;
        instr_id  = ins;
        pc_id     = pc;
        cond_true = ct;
        stall     = st;
        if (!rst_v) begin
            m_slot  = 0;
            m_annul = 0;
            m_taken = 0;
            m_acnt  = 0;
        end
        op    = int'(ins >> 30);
        op2   = int'((ins >> 22) & 32'h7);
        op3   = int'((ins >> 19) & 32'h3F);
        cond  = int'((ins >> 25) & 32'hF);
        a     = ins[29];
        call  = (op == 1);
        bicc  = (op == 0) && (op2 == 2);
        jmpl  = (op == 2) && (op3 == 56);
        taken = bicc && ((cond == 8) || ((cond != 0) && ct));
        live  = !m_slot && !m_annul && !st;
        tgt   = 0;
        if (bicc) begin
            off = longint'(ins & 32'h003F_FFFF);
            if (off >= 64'd2097152) off = off - 64'd4194304;
            tgt = (longint'(pc) + off * 4) & 64'hFFFF_FFFF;
        end else if (call) begin
            off = longint'(ins & 32'h3FFF_FFFF);
            tgt = (longint'(pc) + off * 4) & 64'hFFFF_FFFF;
        end
        e.ta       = tgt[31:0];
        e.if_sel   = !live ? 2'd0 : (taken || call) ? 2'd2 : jmpl ? 2'd1 : 2'd0;
        e.ch_clear = live && bicc && a && (!taken || cond == 8);
        e.en       = !st;
        e.id_valid = !m_annul;
        e.in_dslot = m_slot;
        e.ct       = 16'(m_taken);
        e.ca       = 16'(m_acnt);
        e.seq      = issued;
        sbq.push_back(e);
        issued++;
        if (rst_v && !st) begin
            if (e.if_sel != 0 && m_taken < 65535) m_taken++;
            if (e.ch_clear && m_acnt < 65535) m_acnt++;
            if (m_slot || m_annul) begin
                m_slot  = 0;
                m_annul = 0;
            end else if (e.ch_clear) begin
                m_annul = 1;
            end else if (call || bicc || jmpl) begin
                m_slot = 1;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [3:0]  c;
        w = $urandom;
        c = 4'($urandom_range(15, 0));
        case ($urandom_range(4, 0))
            0, 1:    w = {2'b00, w[29], c, 3'b010, w[21:0]};
            2:       w = {2'b01, w[29:0]};
            3:       w = {2'b10, w[29:25], 6'b111000, w[18:0]};
            default: w = w;
        endcase
        return w;
    endfunction

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checkOutput(mon_e);
        end
    end

    localparam logic [31:0] NOP  = 32'h0100_0000;
    localparam logic [31:0] BA0  = 32'h1080_0004;
    localparam logic [31:0] BNE1 = 32'h3280_0003;
    localparam logic [31:0] CALL = 32'h7FFF_FFFF;
    localparam logic [31:0] JMPL = 32'h81C0_0000;

    initial begin
        R = 1'b1; instr_id = '0; pc_id = '0; cond_true = 1'b0; stall = 1'b0;
        // Reset with a live BA on the bus, then with an all-zero instruction.
        applyStimulus(0, BA0, 32'h40, 0, 0);
        applyStimulus(0, BA0, 32'h40, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 32'h0, 32'h0, 0, 0);
        // BA,a=0 then its delay slot.
        applyStimulus(1, BA0, 32'h40, 0, 0);
        applyStimulus(1, NOP, 32'h44, 0, 0);
        applyStimulus(1, NOP, 32'h48, 0, 0);
        // BNE,a=1 not taken annuls its slot.
        applyStimulus(1, BNE1, 32'h4C, 0, 0);
        applyStimulus(1, NOP, 32'h50, 0, 0);
        applyStimulus(1, NOP, 32'h54, 0, 0);
        // CALL with the most negative-wrapping displacement.
        applyStimulus(1, CALL, 32'h100, 0, 0);
        applyStimulus(1, NOP, 32'h104, 0, 0);
        // JMPL sitting in a BA delay slot is ignored.
        applyStimulus(1, BA0, 32'h200, 0, 0);
        applyStimulus(1, JMPL, 32'h204, 0, 0);
        applyStimulus(1, NOP, 32'h208, 0, 0);
        // Taken branch held by a three-cycle stall.
        applyStimulus(1, BA0, 32'h300, 1, 1);
        applyStimulus(1, BA0, 32'h300, 1, 1);
        applyStimulus(1, BA0, 32'h300, 1, 1);
        applyStimulus(1, BA0, 32'h300, 1, 0);
        applyStimulus(1, BA0, 32'h304, 1, 0);
        applyStimulus(1, NOP, 32'h308, 0, 0);
        // Reset while an annulled slot is pending.
        applyStimulus(1, BNE1, 32'h400, 0, 0);
        applyStimulus(0, NOP, 32'h404, 0, 0);
        applyStimulus(1, NOP, 32'h404, 0, 0);
        applyStimulus(1, BA0, 32'h408, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(199, 0) != 0), rand_instr(), $urandom,
                          1'($urandom_range(1, 0)), ($urandom_range(4, 0) == 0));
        end
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sbq.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain actual=%0d required=0", sbq.size());
        end
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
